ssp_clk_gen: RTL

Programmable serial-clock generator for the SSP block, replacing the fixed divide-by-2 SSPCLK. Derives the serial bit clock from PCLK as PCLK / (CPSDVSR × (1 + SCR)), with even prescale, programmable polarity and a clean start/stop gate. It also emits one-cycle leading- and trailing-edge strobes so the shift and sample logic can stay entirely in the PCLK domain.

---
 rtl/ssp_clk_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/ssp_clk_gen.sv
// ssp_clk_gen: programmable SSP serial-clock generator, SCLK = PCLK / (CPSDVSR * (1 + SCR)).
// Emits one-cycle LEAD/TRAIL strobes so downstream shift/sample logic stays in the PCLK domain.
`default_nettype none

module ssp_clk_gen #(
    parameter int PRE_W = 8,
    parameter int SCR_W = 8
) (
    input  logic             PCLK,
    input  logic             CLEAR,
    input  logic             EN,
    input  logic [PRE_W-1:0] CPSDVSR,
    input  logic [SCR_W-1:0] SCR,
    input  logic             CPOL,
    output logic             SCLK,
    output logic             LEAD,
    output logic             TRAIL,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_ONE = 1;
    localparam logic [SCR_W-1:0] SCR_ONE = 1;

    state_t           state;
    logic [PRE_W-1:0] half_pre;   // P/2, LSB of CPSDVSR already discarded
    logic [SCR_W-1:0] scr_sh;
    logic             cpol_sh;
    logic [PRE_W-1:0] pre_cnt;
    logic [SCR_W-1:0] rate_cnt;
    logic             lead_next;
    logic [PRE_W-1:0] pre_last;
    logic             pre_wrap;
    logic             toggle;

    // P below 2 collapses to P/2 = 0, which behaves exactly like P = 2.
    always_comb begin
        pre_last = (half_pre == '0) ? '0 : half_pre - PRE_ONE;
        pre_wrap = (pre_cnt == pre_last);
        toggle   = pre_wrap && (rate_cnt == scr_sh);
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state     <= IDLE;
            half_pre  <= '0;
            scr_sh    <= '0;
            cpol_sh   <= 1'b0;
            pre_cnt   <= '0;
            rate_cnt  <= '0;
            lead_next <= 1'b1;
            SCLK      <= 1'b0;
            LEAD      <= 1'b0;
            TRAIL     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            LEAD  <= 1'b0;
            TRAIL <= 1'b0;
            case (state)
                IDLE: begin
                    half_pre  <= CPSDVSR >> 1;
                    scr_sh    <= SCR;
                    cpol_sh   <= CPOL;
                    SCLK      <= cpol_sh;
                    pre_cnt   <= '0;
                    rate_cnt  <= '0;
                    lead_next <= 1'b1;
                    if (EN) begin
                        state <= RUN;
                        BUSY  <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (state == RUN && !EN) begin
                        state <= STOP;
                    end else if (state == STOP && EN) begin
                        state <= RUN;
                    end
                    if (!toggle) begin
                        if (pre_wrap) begin
                            pre_cnt  <= '0;
                            rate_cnt <= rate_cnt + SCR_ONE;
                        end else begin
                            pre_cnt <= pre_cnt + PRE_ONE;
                        end
                    end else begin
                        pre_cnt   <= '0;
                        rate_cnt  <= '0;
                        lead_next <= !lead_next;
                        if (lead_next) begin
                            SCLK <= !cpol_sh;
                            LEAD <= 1'b1;
                        end else begin
                            SCLK  <= cpol_sh;
                            TRAIL <= 1'b1;
                            // A stop request is honoured only here, so no partial period escapes.
                            if (!EN) begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
